wish_packetarbiter: RTL and testbench
=====================================

Name: wish_packetArbiter

Overview:
- Round-robin arbiter that shares one Wishbone-style stream sink between N_SRC stream sources, e.g. several file-reader stimulus sources feeding one DUT input.
- Grant is packet-locked: once a source is granted, it keeps the sink until its end-of-packet beat (tgc[1]=1) is acknowledged.
- Sits between the simulation stimulus sources and the consumer; the datapath is a combinational mux, and arbitration is a registered FSM.

Parameters:
- N_SRC, 2, number of sources (>=1).
- DATA_WIDTH, 64, beat width in bits (matches a source carrying N*width integers).
- TIMEOUT, 16, idle-cycle limit for the watchdog (used only with the optional feature; >=1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-low reset.
- s_dat_i  in  N_SRC*DATA_WIDTH  source data; source k at [k*DATA_WIDTH +: DATA_WIDTH].
- s_stb_i  in  N_SRC  source strobe.
- s_cyc_i  in  N_SRC  source cycle.
- s_tgc_i  in  2*N_SRC  source tags; source k at [2k +: 2]; bit1 = end-of-packet.
- s_ack_o  out  N_SRC  ack back to each source.
- m_dat_o  out  DATA_WIDTH  sink data.
- m_stb_o  out  1  sink strobe.
- m_cyc_o  out  1  sink cycle.
- m_tgc_o  out  2  sink tag.
- m_ack_i  in  1  sink ack.
- gnt_o  out  N_SRC  one-hot current grant; all zero when idle.
- err_o  out  1  one-cycle watchdog pulse; tied 0 without the optional feature.

Behaviour:
- Request from source k: s_stb_i[k] & s_cyc_i[k].
- Reset (rst_i=0, async): state=IDLE, gnt=0, rr_ptr=0, err_o=0. All combinational outputs evaluate to 0 (m_stb_o, m_cyc_o, m_dat_o, m_tgc_o, s_ack_o). A reset mid-packet drops the packet immediately, with no completion.
- FSM states: IDLE, LOCKED.
- IDLE:
  - m_cyc_o=m_stb_o=0, m_dat_o=0, m_tgc_o=0, s_ack_o=0, gnt_o=0.
  - If any request is present, choose the first requester scanning k = rr_ptr, rr_ptr+1, ... mod N_SRC.
  - Register the grant and go to LOCKED on the next edge.
  - Arbitration latency: exactly 1 cycle from request to m_stb_o.
- LOCKED (grant g):
  - m_cyc_o=1.
  - m_stb_o = s_stb_i[g] & s_cyc_i[g].
  - m_dat_o = s_dat_i[g], m_tgc_o = s_tgc_i[g], both passed combinationally.
  - s_ack_o[g] = m_ack_i & m_stb_o; all other s_ack_o = 0. Non-granted sources are held off.
  - Beat transfer: m_stb_o & m_ack_i.
  - Beat with m_tgc_o[1]=1 transferred → IDLE next edge, rr_ptr = (g+1) mod N_SRC.
  - Beat with tgc[1]=0 transferred → stay LOCKED.
  - s_cyc_i[g] deasserted → abandon: IDLE next edge, rr_ptr = (g+1) mod N_SRC, no beat transferred that cycle.
  - m_stb_o low while locked: stay LOCKED, with m_cyc_o still 1.
- Ack handling:
  - m_ack_i is ignored when m_stb_o=0.
  - m_ack_i is ignored in IDLE; it is never forwarded.
- Fairness:
  - After a packet completes, the just-served source has lowest priority.
  - With all sources requesting continuously, packets alternate strictly 0,1,...,N_SRC-1,0.
- Gap between packets: at least 1 IDLE cycle.
- N_SRC=1: the same FSM applies; rr_ptr stays 0.
- A single-beat packet (tgc[1]=1 on the first beat) is legal: LOCKED for 1 cycle when acked immediately.

Optional Feature:
- Macro: WISH_PACKET_ARBITER_WATCHDOG_EN.
- Defined:
  - A counter clears on entry to LOCKED and on every transferred beat.
  - It increments on each LOCKED cycle with m_stb_o=0.
  - On reaching TIMEOUT: err_o=1 for one cycle, go to IDLE, rr_ptr advances.
  - Resets asynchronously to 0.
- Undefined: no counter; err_o constant 0; the grant is held indefinitely while s_cyc_i[g]=1.

Test Plan:
- Reset then no requests: outputs stay 0, gnt_o=0 for 10 cycles. Assert rst_i=0 mid-packet → m_cyc_o=0 and gnt_o=0 immediately, without waiting for a clock edge.
- Single source: src0 sends beats 0x11,0x22,0x33 (tgc[1] on 0x33), m_ack_i=1 throughout → m_dat_o sequence 11,22,33 starting 1 cycle after request; s_ack_o=01 on each; IDLE after 0x33.
- Both sources request 3-beat packets continuously from reset → order src0,src1,src0,src1; src1 data never appears during a src0 packet; s_ack_o[1]=0 while gnt_o=01.
- Backpressure: m_ack_i low for 5 cycles mid-packet → m_dat_o/m_stb_o held, no s_ack_o, grant unchanged; transfer resumes when ack returns.
- Abandon: src1 drops s_cyc_i after beat 1 of 3 → IDLE next edge; a pending src0 is granted the following cycle.
- Watchdog (macro defined, TIMEOUT=4): granted source holds stb low for 4 cycles mid-packet → err_o pulses once, grant released; macro undefined → grant held, err_o=0.

Source files
------------

// File: rtl/wish_packetarbiter_if.sv
// Bundle of N_SRC stream sources and one stream sink around wish_packetarbiter.
// slave modport is the arbiter's view; master modport is the sources/sink side.
interface wish_packetarbiter_if #(
  parameter int unsigned N_SRC      = 2,
  parameter int unsigned DATA_WIDTH = 64
);
  logic [N_SRC*DATA_WIDTH-1:0] s_dat_i;
  logic [N_SRC-1:0]            s_stb_i;
  logic [N_SRC-1:0]            s_cyc_i;
  logic [2*N_SRC-1:0]          s_tgc_i;
  logic [N_SRC-1:0]            s_ack_o;
  logic [DATA_WIDTH-1:0]       m_dat_o;
  logic                        m_stb_o;
  logic                        m_cyc_o;
  logic [1:0]                  m_tgc_o;
  logic                        m_ack_i;

  modport slave (
    input  s_dat_i, s_stb_i, s_cyc_i, s_tgc_i, m_ack_i,
    output s_ack_o, m_dat_o, m_stb_o, m_cyc_o, m_tgc_o
  );

  modport master (
    output s_dat_i, s_stb_i, s_cyc_i, s_tgc_i, m_ack_i,
    input  s_ack_o, m_dat_o, m_stb_o, m_cyc_o, m_tgc_o
  );
endinterface

// File: rtl/wish_packetarbiter.sv
// Packet-locked round-robin arbiter sharing one stream sink between N_SRC sources.
// Optional idle watchdog enabled by defining WISH_PACKET_ARBITER_WATCHDOG_EN.
module wish_packetarbiter #(
  parameter int unsigned N_SRC      = 2,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  wish_packetarbiter_if.slave  bus,
  output logic [N_SRC-1:0]     gnt_o,
  output logic                 err_o
);

  localparam int unsigned IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           r_state, w_state_nxt;
  logic [IW-1:0]    r_gnt, r_rr;
  logic [IW-1:0]    w_gnt_nxt, w_rr_nxt, w_rr_adv, w_pick, w_idx;
  logic [N_SRC-1:0] w_req;
  logic             w_any, w_xfer, w_cyc_g, w_wd_hit;

  assign w_req    = bus.s_stb_i & bus.s_cyc_i;
  assign w_xfer   = bus.m_stb_o & bus.m_ack_i;
  assign w_rr_adv = (32'(r_gnt) == N_SRC - 1) ? '0 : r_gnt + 1'b1;

  // First requester scanning upward from the round-robin pointer, wrapping.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_idx  = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      w_idx = IW'((32'(r_rr) + i) % N_SRC);
      if (!w_any && w_req[w_idx]) begin
        w_any  = 1'b1;
        w_pick = w_idx;
      end
    end
  end

  always_comb begin
    bus.m_dat_o = '0;
    bus.m_tgc_o = '0;
    bus.m_stb_o = 1'b0;
    bus.m_cyc_o = 1'b0;
    bus.s_ack_o = '0;
    gnt_o       = '0;
    w_cyc_g     = 1'b0;
    if (r_state == LOCKED) begin
      bus.m_cyc_o = 1'b1;
      for (int unsigned k = 0; k < N_SRC; k++) begin
        if (k == 32'(r_gnt)) begin
          bus.m_dat_o    = bus.s_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
          bus.m_tgc_o    = bus.s_tgc_i[2*k +: 2];
          bus.m_stb_o    = w_req[k];
          bus.s_ack_o[k] = bus.m_ack_i & w_req[k];
          gnt_o[k]       = 1'b1;
          w_cyc_g        = bus.s_cyc_i[k];
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_rr_nxt    = r_rr;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = LOCKED;
          w_gnt_nxt   = w_pick;
        end
      end
      LOCKED: begin
        if (!w_cyc_g || (w_xfer && bus.m_tgc_o[1]) || w_wd_hit) begin
          w_state_nxt = IDLE;
          w_rr_nxt    = w_rr_adv;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_rr    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_rr    <= w_rr_nxt;
    end
  end

`ifdef WISH_PACKET_ARBITER_WATCHDOG_EN
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  logic [WW-1:0] r_wd;
  logic          r_err;

  // Abandon takes precedence, so a dropped cycle never raises err_o.
  assign w_wd_hit = (r_state == LOCKED) && w_cyc_g && !bus.m_stb_o &&
                    (32'(r_wd) == TIMEOUT - 1);
  assign err_o    = r_err;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_wd_hit;
      if (r_state != LOCKED || w_xfer || w_wd_hit)
        r_wd <= '0;
      else if (!bus.m_stb_o)
        r_wd <= r_wd + 1'b1;
    end
  end
`else
  assign w_wd_hit = 1'b0;
  assign err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_wish_packetarbiter.sv
// Self-checking bench for wish_packetarbiter: vector table, round-robin scoreboard,
// watchdog/stall and asynchronous-reset sequences.
module tb_wish_packetarbiter;

  localparam int unsigned NS = 2;
  localparam int unsigned DW = 64;
  localparam int unsigned TO = 4;
`ifdef WISH_PACKET_ARBITER_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [NS-1:0] gnt;
  logic          err;

  always #5 clk = ~clk;

  wish_packetarbiter_if #(.N_SRC(NS), .DATA_WIDTH(DW)) bus ();

  wish_packetarbiter #(.N_SRC(NS), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus.slave),
    .gnt_o (gnt),
    .err_o (err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] stb, input logic [1:0] cyc,
                       input logic [63:0] d0, input logic [63:0] d1,
                       input logic [1:0] t0, input logic [1:0] t1, input logic ack);
    bus.s_stb_i = stb;
    bus.s_cyc_i = cyc;
    bus.s_dat_i = {d1, d0};
    bus.s_tgc_i = {t1, t0};
    bus.m_ack_i = ack;
  endtask

  typedef struct {
    logic [1:0]  stb, cyc;
    logic [63:0] d0, d1;
    logic [1:0]  t0, t1;
    logic        ack;
    logic [1:0]  e_gnt;
    logic        e_stb, e_cyc;
    logic [63:0] e_dat;
    logic [1:0]  e_tgc, e_sack;
  } vec_t;

  function automatic vec_t mk(logic [1:0] stb, logic [1:0] cyc, logic [63:0] d0,
                              logic [63:0] d1, logic [1:0] t0, logic [1:0] t1,
                              logic ack, logic [1:0] e_gnt, logic e_stb, logic e_cyc,
                              logic [63:0] e_dat, logic [1:0] e_tgc, logic [1:0] e_sack);
    vec_t v;
    v.stb = stb; v.cyc = cyc; v.d0 = d0; v.d1 = d1; v.t0 = t0; v.t1 = t1; v.ack = ack;
    v.e_gnt = e_gnt; v.e_stb = e_stb; v.e_cyc = e_cyc; v.e_dat = e_dat;
    v.e_tgc = e_tgc; v.e_sack = e_sack;
    return v;
  endfunction

  typedef struct {
    logic [63:0] dat;
    int          src;
  } beat_t;

  vec_t  tbl[$];
  beat_t sb[$];

  initial begin
    int bc[NS];
    int pc[NS];
    beat_t b;

    // Single 3-beat packet, backpressure, abandon with pending src0, long stall.
    tbl.push_back(mk(2'b01, 2'b01, 64'h11, 0, 0, 0, 1, 2'b00, 0, 0, 64'h0,  0, 2'b00));
    tbl.push_back(mk(2'b01, 2'b01, 64'h11, 0, 0, 0, 1, 2'b01, 1, 1, 64'h11, 0, 2'b01));
    tbl.push_back(mk(2'b01, 2'b01, 64'h22, 0, 0, 0, 1, 2'b01, 1, 1, 64'h22, 0, 2'b01));
    tbl.push_back(mk(2'b01, 2'b01, 64'h33, 0, 2, 0, 1, 2'b01, 1, 1, 64'h33, 2, 2'b01));
    tbl.push_back(mk(2'b00, 2'b00, 64'h0,  0, 0, 0, 1, 2'b00, 0, 0, 64'h0,  0, 2'b00));
    tbl.push_back(mk(2'b01, 2'b01, 64'h44, 0, 0, 0, 0, 2'b00, 0, 0, 64'h0,  0, 2'b00));
    tbl.push_back(mk(2'b01, 2'b01, 64'h44, 0, 0, 0, 1, 2'b01, 1, 1, 64'h44, 0, 2'b01));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(2'b11, 2'b11, 64'h55, 64'hAA, 0, 2, 0, 2'b01, 1, 1, 64'h55, 0, 2'b00));
    tbl.push_back(mk(2'b11, 2'b11, 64'h55, 64'hAA, 2, 2, 1, 2'b01, 1, 1, 64'h55, 2, 2'b01));
    tbl.push_back(mk(2'b10, 2'b10, 64'h0,  64'hA1, 0, 0, 1, 2'b00, 0, 0, 64'h0,  0, 2'b00));
    tbl.push_back(mk(2'b11, 2'b11, 64'h66, 64'hA1, 0, 0, 1, 2'b10, 1, 1, 64'hA1, 0, 2'b10));
    tbl.push_back(mk(2'b11, 2'b01, 64'h66, 64'hA2, 0, 0, 1, 2'b10, 0, 1, 64'hA2, 0, 2'b00));
    tbl.push_back(mk(2'b01, 2'b01, 64'h66, 64'h0,  0, 0, 1, 2'b00, 0, 0, 64'h0,  0, 2'b00));
    tbl.push_back(mk(2'b01, 2'b01, 64'h66, 64'h0,  2, 0, 1, 2'b01, 1, 1, 64'h66, 2, 2'b01));
    tbl.push_back(mk(2'b00, 2'b00, 64'h0,  64'h0,  0, 0, 1, 2'b00, 0, 0, 64'h0,  0, 2'b00));
    tbl.push_back(mk(2'b01, 2'b01, 64'h77, 64'h0,  0, 0, 1, 2'b00, 0, 0, 64'h0,  0, 2'b00));
    tbl.push_back(mk(2'b01, 2'b01, 64'h77, 64'h0,  0, 0, 1, 2'b01, 1, 1, 64'h77, 0, 2'b01));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(2'b00, 2'b01, 64'h88, 64'h0, 0, 0, 1, 2'b01, 0, 1, 64'h88, 0, 2'b00));
    tbl.push_back(mk(2'b01, 2'b01, 64'h88, 64'h0,  2, 0, 1, 2'b01, 1, 1, 64'h88, 2, 2'b01));
    tbl.push_back(mk(2'b00, 2'b00, 64'h0,  64'h0,  0, 0, 1, 2'b00, 0, 0, 64'h0,  0, 2'b00));

    // Reset state and quiet idle.
    drive(0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("reset outputs", {62'h0, bus.m_stb_o, bus.m_cyc_o}, 64'h0);
    chk("reset gnt/ack/err", {59'h0, gnt, bus.s_ack_o, err}, 64'h0);
    chk("reset dat", bus.m_dat_o, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d", i),
          {57'h0, gnt, bus.m_stb_o, bus.m_cyc_o, bus.m_tgc_o, err}, 64'h0);
    end

    // Both sources stream 3-beat packets; expect strict alternation 0,1,0,1.
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 2; k++)
        for (int j = 0; j < 3; j++) begin
          b.dat = 64'hA000 + 64'(k * 256 + p * 16 + j);
          b.src = k;
          sb.push_back(b);
        end
    for (int k = 0; k < NS; k++) begin
      bc[k] = 0;
      pc[k] = 0;
    end
    for (int cyc = 0; cyc < 100 && sb.size() > 0; cyc++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NS; k++) begin
        bus.s_stb_i[k] = (pc[k] < 2);
        bus.s_cyc_i[k] = (pc[k] < 2);
        bus.s_dat_i[k*DW +: DW] = 64'hA000 + 64'(k * 256 + pc[k] * 16 + bc[k]);
        bus.s_tgc_i[2*k +: 2] = (bc[k] == 2) ? 2'b10 : 2'b00;
      end
      bus.m_ack_i = 1'b1;
      @(negedge clk);
      chk("rr ack outside grant", 64'(bus.s_ack_o & ~gnt), 64'h0);
      if (bus.m_stb_o && bus.m_ack_i) begin
        b = sb.pop_front();
        chk("rr data", bus.m_dat_o, b.dat);
        chk("rr ack", 64'(bus.s_ack_o), 64'(1 << b.src));
      end
      for (int k = 0; k < NS; k++)
        if (bus.s_ack_o[k]) begin
          bc[k]++;
          if (bc[k] == 3) begin
            bc[k] = 0;
            pc[k]++;
          end
        end
    end
    chk("rr beats left", 64'(sb.size()), 64'h0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 1);
    repeat (2) @(negedge clk);

    for (int r = 0; r < tbl.size(); r++) begin
      @(posedge clk);
      #1;
      drive(tbl[r].stb, tbl[r].cyc, tbl[r].d0, tbl[r].d1, tbl[r].t0, tbl[r].t1, tbl[r].ack);
      @(negedge clk);
      chk($sformatf("row%0d gnt", r), 64'(gnt), 64'(tbl[r].e_gnt));
      chk($sformatf("row%0d stb/cyc/err", r), {61'h0, bus.m_stb_o, bus.m_cyc_o, err},
          {61'h0, tbl[r].e_stb, tbl[r].e_cyc, 1'b0});
      chk($sformatf("row%0d dat", r), bus.m_dat_o, tbl[r].e_dat);
      chk($sformatf("row%0d tgc/ack", r), {60'h0, bus.m_tgc_o, bus.s_ack_o},
          {60'h0, tbl[r].e_tgc, tbl[r].e_sack});
    end

    // Strobe stalls for six cycles mid-packet while the cycle stays asserted.
    @(posedge clk); #1; drive(2'b01, 2'b01, 64'h99, 0, 0, 0, 1);
    @(negedge clk);
    @(posedge clk); #1; drive(2'b01, 2'b01, 64'h99, 0, 0, 0, 1);
    @(negedge clk);
    chk("stall start gnt", 64'(gnt), 64'h1);
    for (int n = 1; n <= 6; n++) begin
      logic released;
      @(posedge clk); #1; drive(2'b00, 2'b01, 64'h99, 0, 0, 0, 1);
      @(negedge clk);
      released = WD && (n >= 5);
      chk($sformatf("stall%0d gnt", n), 64'(gnt), released ? 64'h0 : 64'h1);
      chk($sformatf("stall%0d cyc", n), 64'(bus.m_cyc_o), released ? 64'h0 : 64'h1);
      chk($sformatf("stall%0d err", n), 64'(err), (WD && n == 5) ? 64'h1 : 64'h0);
    end
    @(posedge clk); #1; drive(0, 0, 0, 0, 0, 0, 1);
    repeat (2) @(negedge clk);
    chk("after stall gnt", 64'(gnt), 64'h0);

    // Reset asserted mid-packet clears the grant without a clock edge.
    @(posedge clk); #1; drive(2'b01, 2'b01, 64'hBB, 0, 0, 0, 1);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre-reset gnt/cyc", {61'h0, gnt, bus.m_cyc_o}, {61'h0, 2'b01, 1'b1});
    #2 rst_n = 1'b0;
    #1;
    chk("async reset gnt/cyc/stb", {60'h0, gnt, bus.m_cyc_o, bus.m_stb_o}, 64'h0);
    chk("async reset ack/dat", {bus.s_ack_o, bus.m_dat_o[61:0]}, 64'h0);
    repeat (2) @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset gnt", 64'(gnt), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
